// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit: eight ops, accumulator operand,
// zero/parity flags, and an elastic valid/ready chain of 1 or 2 slots.
module logic_unit_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             use_acc,
    input  logic             acc_we,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_XNOR = 3'b101,
        OP_ANDN = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic             accept;
    logic             adv0;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] res_c;

    logic             v0_q, v0_d;
    logic [WIDTH-1:0] r0_q, r0_d;
    logic             z0_q, z0_d;
    logic             p0_q, p0_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    always_comb begin
        op_a  = use_acc ? acc_q : a;
        res_c = '0;
        case (op_e'(op))
            OP_AND:  res_c = op_a & b;
            OP_OR:   res_c = op_a | b;
            OP_XOR:  res_c = op_a ^ b;
            OP_NOR:  res_c = ~(op_a | b);
            OP_NAND: res_c = ~(op_a & b);
            OP_XNOR: res_c = ~(op_a ^ b);
            OP_ANDN: res_c = op_a & ~b;
            OP_PASS: res_c = op_a;
            default: res_c = '0;
        endcase

        // adv0 depends only on slot state and out_ready, never on in_valid
        in_ready = !v0_q || adv0;
        accept   = in_valid && in_ready;

        v0_d = accept || (v0_q && !adv0);
        r0_d = accept ? res_c : r0_q;
        z0_d = accept ? (res_c == '0) : z0_q;
        p0_d = accept ? ^res_c : p0_q;

        // Clear wins over a same-cycle write and ignores the handshake
        if (acc_clr) begin
            acc_d = '0;
        end else if (accept && acc_we) begin
            acc_d = res_c;
        end else begin
            acc_d = acc_q;
        end
        acc = acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q  <= 1'b0;
            r0_q  <= '0;
            z0_q  <= 1'b0;
            p0_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            v0_q  <= v0_d;
            r0_q  <= r0_d;
            z0_q  <= z0_d;
            p0_q  <= p0_d;
            acc_q <= acc_d;
        end
    end

    if (STAGES == 2) begin : g_two
        logic             adv1;
        logic             v1_q, v1_d;
        logic [WIDTH-1:0] r1_q, r1_d;
        logic             z1_q, z1_d;
        logic             p1_q, p1_d;

        always_comb begin
            adv1      = v1_q && out_ready;
            adv0      = v0_q && (!v1_q || adv1);
            v1_d      = adv0 || (v1_q && !adv1);
            r1_d      = adv0 ? r0_q : r1_q;
            z1_d      = adv0 ? z0_q : z1_q;
            p1_d      = adv0 ? p0_q : p1_q;
            out_valid = v1_q;
            result    = r1_q;
            zero      = z1_q;
            parity    = p1_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q <= 1'b0;
                r1_q <= '0;
                z1_q <= 1'b0;
                p1_q <= 1'b0;
            end else begin
                v1_q <= v1_d;
                r1_q <= r1_d;
                z1_q <= z1_d;
                p1_q <= p1_d;
            end
        end
    end else begin : g_one
        always_comb begin
            adv0      = v0_q && out_ready;
            out_valid = v0_q;
            result    = r0_q;
            zero      = z0_q;
            parity    = p0_q;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed cases plus random traffic on three
// configurations, scored against a truth-table reference model.
module tb_logic_unit_pipe;

    logic clk;
    logic rst_n;
    int   n_tot;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // m_: WIDTH=32 STAGES=2, s_: WIDTH=8 STAGES=1, t_: WIDTH=1 STAGES=2
    logic        m_in_valid, m_in_ready, m_use_acc, m_acc_we, m_acc_clr;
    logic        m_out_valid, m_out_ready, m_zero, m_parity;
    logic [2:0]  m_op;
    logic [31:0] m_a, m_b, m_result, m_acc;

    logic        s_in_valid, s_in_ready, s_use_acc, s_acc_we, s_acc_clr;
    logic        s_out_valid, s_out_ready, s_zero, s_parity;
    logic [2:0]  s_op;
    logic [7:0]  s_a, s_b, s_result, s_acc;

    logic        t_in_valid, t_in_ready, t_use_acc, t_acc_we, t_acc_clr;
    logic        t_out_valid, t_out_ready, t_zero, t_parity;
    logic [2:0]  t_op;
    logic [0:0]  t_a, t_b, t_result, t_acc;

    logic_unit_pipe #(.WIDTH(32), .STAGES(2)) u_m (
        .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .op(m_op), .a(m_a), .b(m_b), .use_acc(m_use_acc), .acc_we(m_acc_we),
        .acc_clr(m_acc_clr), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .result(m_result), .zero(m_zero), .parity(m_parity), .acc(m_acc)
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op(s_op), .a(s_a), .b(s_b), .use_acc(s_use_acc), .acc_we(s_acc_we),
        .acc_clr(s_acc_clr), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .result(s_result), .zero(s_zero), .parity(s_parity), .acc(s_acc)
    );

    logic_unit_pipe #(.WIDTH(1), .STAGES(2)) u_t (
        .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .op(t_op), .a(t_a), .b(t_b), .use_acc(t_use_acc), .acc_we(t_acc_we),
        .acc_clr(t_acc_clr), .out_valid(t_out_valid), .out_ready(t_out_ready),
        .result(t_result), .zero(t_zero), .parity(t_parity), .acc(t_acc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truth table per op, indexed by {opA_bit, b_bit}
    localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0001,
                                      4'b0111, 4'b1001, 4'b0100, 4'b1100};

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] x,
                                           input logic [31:0] y, input int w);
        logic [3:0]  tt;
        logic [31:0] r;
        tt = TT[op];
        r  = '0;
        for (int i = 0; i < w; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    function automatic int ones(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    // Scoreboards: sampled on the falling edge, reflecting the coming rising edge
    logic [31:0] m_q[$], s_q[$], t_q[$];
    logic [31:0] m_accm, s_accm, t_accm, m_last, s_last, t_last;
    logic        m_held, s_held, t_held;

    always @(negedge clk) begin : mon_m
        logic [31:0] r, e;
        if (!rst_n) begin
            m_q.delete(); m_accm = '0; m_held = 1'b0;
        end else begin
            check("m_acc", m_acc, m_accm);
            if (m_held) begin
                check("m_hold_valid", 32'(m_out_valid), 1);
                check("m_hold_result", m_result, m_last);
            end
            if (m_out_valid && m_out_ready) begin
                if (m_q.size() == 0) check("m_extra_output", 1, 0);
                else begin
                    e = m_q.pop_front();
                    check("m_result", m_result, e);
                    check("m_zero", 32'(m_zero), 32'(ones(e) == 0));
                    check("m_parity", 32'(m_parity), 32'(ones(e) % 2));
                end
            end
            r = ref_op(m_op, m_use_acc ? m_accm : m_a, m_b, 32);
            if (m_in_valid && m_in_ready) m_q.push_back(r);
            if (m_acc_clr) m_accm = '0;
            else if (m_in_valid && m_in_ready && m_acc_we) m_accm = r;
            m_held = m_out_valid && !m_out_ready;
            m_last = m_result;
        end
    end

    always @(negedge clk) begin : mon_s
        logic [31:0] r, e;
        if (!rst_n) begin
            s_q.delete(); s_accm = '0; s_held = 1'b0;
        end else begin
            check("s_acc", 32'(s_acc), s_accm);
            if (s_held) begin
                check("s_hold_valid", 32'(s_out_valid), 1);
                check("s_hold_result", 32'(s_result), s_last);
            end
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) check("s_extra_output", 1, 0);
                else begin
                    e = s_q.pop_front();
                    check("s_result", 32'(s_result), e);
                    check("s_zero", 32'(s_zero), 32'(ones(e) == 0));
                    check("s_parity", 32'(s_parity), 32'(ones(e) % 2));
                end
            end
            r = ref_op(s_op, s_use_acc ? s_accm : 32'(s_a), 32'(s_b), 8);
            if (s_in_valid && s_in_ready) s_q.push_back(r);
            if (s_acc_clr) s_accm = '0;
            else if (s_in_valid && s_in_ready && s_acc_we) s_accm = r;
            s_held = s_out_valid && !s_out_ready;
            s_last = 32'(s_result);
        end
    end

    always @(negedge clk) begin : mon_t
        logic [31:0] r, e;
        if (!rst_n) begin
            t_q.delete(); t_accm = '0; t_held = 1'b0;
        end else begin
            check("t_acc", 32'(t_acc), t_accm);
            if (t_held) begin
                check("t_hold_valid", 32'(t_out_valid), 1);
                check("t_hold_result", 32'(t_result), t_last);
            end
            if (t_out_valid && t_out_ready) begin
                if (t_q.size() == 0) check("t_extra_output", 1, 0);
                else begin
                    e = t_q.pop_front();
                    check("t_result", 32'(t_result), e);
                    check("t_zero", 32'(t_zero), 32'(ones(e) == 0));
                    check("t_parity", 32'(t_parity), 32'(ones(e) % 2));
                end
            end
            r = ref_op(t_op, t_use_acc ? t_accm : 32'(t_a), 32'(t_b), 1);
            if (t_in_valid && t_in_ready) t_q.push_back(r);
            if (t_acc_clr) t_accm = '0;
            else if (t_in_valid && t_in_ready && t_acc_we) t_accm = r;
            t_held = t_out_valid && !t_out_ready;
            t_last = 32'(t_result);
        end
    end

    task automatic drive_in(input int u, input logic v, input logic [2:0] op,
                            input logic [31:0] x, input logic [31:0] y);
        case (u)
            0: begin m_in_valid = v; m_op = op; m_a = x; m_b = y;
                     m_use_acc = 0; m_acc_we = 0; m_acc_clr = 0; end
            1: begin s_in_valid = v; s_op = op; s_a = x[7:0]; s_b = y[7:0];
                     s_use_acc = 0; s_acc_we = 0; s_acc_clr = 0; end
            default: begin t_in_valid = v; t_op = op; t_a = x[0:0]; t_b = y[0:0];
                     t_use_acc = 0; t_acc_we = 0; t_acc_clr = 0; end
        endcase
    endtask

    function automatic logic [34:0] outs(input int u);
        // {out_valid, zero, parity, result}
        case (u)
            0: return {m_out_valid, m_zero, m_parity, m_result};
            1: return {s_out_valid, s_zero, s_parity, 24'b0, s_result};
            default: return {t_out_valid, t_zero, t_parity, 31'b0, t_result};
        endcase
    endfunction

    // One isolated op with out_ready high; checks latency, result and flags
    task automatic d_op(input string tag, input int u, input int lat, input logic [2:0] op,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] er,
                        input logic ez, input logic ep);
        logic [34:0] o;
        @(posedge clk); #1;
        drive_in(u, 1'b1, op, x, y);
        @(negedge clk);
        o = outs(u);
        check({tag, "_pre_valid"}, 32'(o[34]), 0);
        @(posedge clk); #1;
        drive_in(u, 1'b0, op, x, y);
        for (int c = 1; c < lat; c++) begin
            @(negedge clk);
            o = outs(u);
            check({tag, "_early_valid"}, 32'(o[34]), 0);
            @(posedge clk);
        end
        @(negedge clk);
        o = outs(u);
        check({tag, "_valid"}, 32'(o[34]), 1);
        check({tag, "_result"}, o[31:0], er);
        check({tag, "_zero"}, 32'(o[33]), 32'(ez));
        check({tag, "_parity"}, 32'(o[32]), 32'(ep));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        n_tot = 0;
        n_bad = 0;
        rst_n = 1'b0;
        for (int u = 0; u < 3; u++) drive_in(u, 1'b0, 3'd0, 0, 0);
        m_out_ready = 1; s_out_ready = 1; t_out_ready = 1;
        @(negedge clk); @(negedge clk);
        check("rst_m_valid", 32'(m_out_valid), 0);
        check("rst_m_result", m_result, 0);
        check("rst_m_flags", 32'({m_zero, m_parity}), 0);
        check("rst_m_acc", m_acc, 0);
        check("rst_s_valid", 32'(s_out_valid), 0);
        check("rst_t_valid", 32'(t_out_valid), 0);
        #2 rst_n = 1'b1;

        d_op("and", 0, 2, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0);
        d_op("xor", 0, 2, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0);
        d_op("andn", 0, 2, 3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0, 0, 0);
        d_op("flag0", 0, 2, 3'b010, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 1, 0);
        d_op("flag1", 0, 2, 3'b001, 32'h1, 32'h0, 32'h1, 0, 1);
        d_op("s_nand", 1, 1, 3'b100, 32'hC3, 32'h0F, 32'hFC, 0, 0);
        d_op("s_flag0", 1, 1, 3'b010, 32'hA5, 32'hA5, 0, 1, 0);
        d_op("s_xnor", 1, 1, 3'b101, 32'h81, 32'h80, 32'hFE, 0, 1);
        d_op("t_or", 2, 2, 3'b001, 32'h1, 32'h0, 32'h1, 0, 1);
        d_op("t_xor", 2, 2, 3'b010, 32'h1, 32'h1, 32'h0, 1, 0);

        // Backpressure: third op held while both slots are full
        @(posedge clk); #1;
        m_out_ready = 0;
        drive_in(0, 1'b1, 3'b000, 32'h1111_0000, 32'hFFFF_FFFF);
        @(negedge clk); check("bp_ready1", 32'(m_in_ready), 1);
        @(posedge clk); #1;
        drive_in(0, 1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
        @(negedge clk); check("bp_ready2", 32'(m_in_ready), 1);
        @(posedge clk); #1;
        drive_in(0, 1'b1, 3'b010, 32'h0F0F_0F0F, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("bp_full_ready", 32'(m_in_ready), 0);
            check("bp_full_valid", 32'(m_out_valid), 1);
            check("bp_full_result", m_result, 32'h1111_0000);
            @(posedge clk); #1;
        end
        m_out_ready = 1;
        @(negedge clk);
        check("bp_out1", m_result, 32'h1111_0000);
        check("bp_ready3", 32'(m_in_ready), 1);
        @(posedge clk); #1;
        m_in_valid = 0;
        @(negedge clk); check("bp_out2", m_result, 32'h0000_00FF);
        check("bp_out2_valid", 32'(m_out_valid), 1);
        @(negedge clk); check("bp_out3", m_result, 32'h0F0F_0F0F);
        check("bp_out3_valid", 32'(m_out_valid), 1);
        @(negedge clk); check("bp_drained", 32'(m_out_valid), 0);

        // Accumulator chain
        @(posedge clk); #1;
        m_acc_clr = 1;
        @(posedge clk); #1;
        m_acc_clr = 0; m_in_valid = 1; m_op = 3'b001; m_use_acc = 1; m_acc_we = 1;
        m_b = 32'h0000_000F; m_a = 32'hFFFF_FFFF;
        @(negedge clk); check("acc_cleared", m_acc, 0);
        @(posedge clk); #1;
        m_b = 32'h0000_00F0;
        @(negedge clk); check("acc_step1", m_acc, 32'h0000_000F);
        @(posedge clk); #1;
        m_in_valid = 0;
        @(negedge clk);
        check("acc_step2", m_acc, 32'h0000_00FF);
        check("acc_res1", m_result, 32'h0000_000F);
        @(negedge clk); check("acc_res2", m_result, 32'h0000_00FF);
        @(posedge clk); #1;
        m_in_valid = 1; m_op = 3'b111; m_use_acc = 0; m_a = 32'h1234_5678;
        m_acc_we = 1; m_acc_clr = 1;
        @(posedge clk); #1;
        m_in_valid = 0; m_acc_clr = 0; m_a = 32'hFFFF_FFFF;
        @(negedge clk); check("acc_clr_wins", m_acc, 0);
        @(posedge clk); #1;
        m_acc_we = 0;
        @(negedge clk); check("acc_we_no_accept", m_acc, 0);

        // Mid-flight reset with both slots occupied
        @(posedge clk); #1;
        m_out_ready = 0;
        drive_in(0, 1'b1, 3'b111, 32'hDEAD_BEEF, 0);
        @(posedge clk); #1;
        drive_in(0, 1'b1, 3'b111, 32'h1234_5678, 0);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 3'b000, 0, 0);
        @(negedge clk);
        check("mid_pre_valid", 32'(m_out_valid), 1);
        check("mid_pre_result", m_result, 32'hDEAD_BEEF);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(m_out_valid), 0);
        check("mid_rst_result", m_result, 0);
        m_out_ready = 1;
        #10 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mid_no_stale", 32'(m_out_valid), 0);
        end

        // Random traffic on all three configurations
        repeat (800) begin
            @(posedge clk); #1;
            m_in_valid = ($urandom_range(0, 9) < 7); m_op = 3'($urandom());
            m_a = $urandom(); m_b = $urandom(); m_use_acc = 1'($urandom());
            m_acc_we = 1'($urandom()); m_acc_clr = ($urandom_range(0, 11) == 0);
            m_out_ready = ($urandom_range(0, 9) < 7);
            s_in_valid = ($urandom_range(0, 9) < 7); s_op = 3'($urandom());
            s_a = 8'($urandom()); s_b = 8'($urandom()); s_use_acc = 1'($urandom());
            s_acc_we = 1'($urandom()); s_acc_clr = ($urandom_range(0, 11) == 0);
            s_out_ready = ($urandom_range(0, 9) < 6);
            t_in_valid = ($urandom_range(0, 9) < 7); t_op = 3'($urandom());
            t_a = 1'($urandom()); t_b = 1'($urandom()); t_use_acc = 1'($urandom());
            t_acc_we = 1'($urandom()); t_acc_clr = ($urandom_range(0, 11) == 0);
            t_out_ready = ($urandom_range(0, 9) < 6);
        end
        @(posedge clk); #1;
        for (int u = 0; u < 3; u++) drive_in(u, 1'b0, 3'd0, 0, 0);
        m_out_ready = 1; s_out_ready = 1; t_out_ready = 1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("m_drain_empty", 32'(m_q.size()), 0);
        check("s_drain_empty", 32'(s_q.size()), 0);
        check("t_drain_empty", 32'(t_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
